// File: rtl/paddle_pkg.sv
// Shared constants and state encoding for the paddle game blocks.
package paddle_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BALL_SIZE     = 10;
    localparam int PADDLE_Y      = 440;
    localparam int PADDLE_W      = 50;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        LOST,
        OVER
    } game_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle pulse on the first clock where the VGA counters sit at the origin,
// independent of how many clocks each pixel lasts.
module frame_tick_gen
    import paddle_pkg::*;
(
    input  logic       clck,
    input  logic       reset,
    input  logic [9:0] vgax,
    input  logic [8:0] vgay,
    output logic       tick
);

    logic at_origin;
    logic origin_q;

    assign at_origin = (vgax == 10'd0) && (vgay == 9'd0);

    always_ff @(posedge clck) begin
        if (reset) begin
            origin_q <= 1'b0;
        end else begin
            origin_q <= at_origin;
        end
    end

    assign tick = at_origin && !origin_q;

endmodule

// File: rtl/game_sequencer.sv
// Paddle game controller: serve timing, per-frame ball update strobe,
// miss detection, lives and saturating score.
module game_sequencer
    import paddle_pkg::*;
#(
    parameter int unsigned MISS_Y       = 470,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               clck,
    input  logic               reset,
    input  logic [9:0]         vgax,
    input  logic [8:0]         vgay,
    input  logic               start_btn,
    input  logic               paddle_hit,
    input  logic [9:0]         ball_y,
    output logic               ball_rst,
    output logic               update,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [9:0]         MISS_Y_V   = 10'(MISS_Y);
    localparam logic [2:0]         LIVES_INIT = 3'(START_LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

    game_state_t        state_q;
    logic               start_prev_q;
    logic [CNT_W-1:0]   serve_cnt_q;
    logic [2:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               update_q;
    logic               ball_rst_q;
    logic               game_over_q;

    logic               tick;
    logic               start_press_d;
    logic               miss_d;
    logic [SCORE_W-1:0] score_inc_d;
    logic [2:0]         lives_dec_d;

    frame_tick_gen u_frame_tick (
        .clck  (clck),
        .reset (reset),
        .vgax  (vgax),
        .vgay  (vgay),
        .tick  (tick)
    );

    assign start_press_d = start_btn && !start_prev_q;
    assign miss_d        = tick && (ball_y >= MISS_Y_V);
    assign score_inc_d   = sat_inc(score_q);
    assign lives_dec_d   = lives_q - 3'd1;

    // Outputs are registered decodes of the current state, so they lag state entry by one cycle.
    always_ff @(posedge clck) begin
        if (reset) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            serve_cnt_q  <= '0;
            lives_q      <= LIVES_INIT;
            score_q      <= '0;
            update_q     <= 1'b0;
            ball_rst_q   <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            update_q     <= tick && (state_q == PLAY);
            ball_rst_q   <= (state_q != PLAY);
            game_over_q  <= (state_q == OVER);
            unique case (state_q)
                IDLE, OVER: begin
                    if (start_press_d) begin
                        state_q     <= SERVE;
                        lives_q     <= LIVES_INIT;
                        score_q     <= '0;
                        serve_cnt_q <= '0;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        serve_cnt_q <= serve_cnt_q + 1'b1;
                        if (serve_cnt_q == SERVE_LAST) begin
                            state_q <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (paddle_hit) begin
                        score_q <= score_inc_d;
                    end
                    if (miss_d) begin
                        state_q <= LOST;
                    end
                end
                LOST: begin
                    lives_q <= lives_dec_d;
                    if (lives_q == 3'd1) begin
                        state_q <= OVER;
                    end else begin
                        state_q     <= SERVE;
                        serve_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ball_rst  = ball_rst_q;
    assign update    = update_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: stimulus pushes expected update cycles and
// output snapshots into queues; a monitor on the falling edge pops and compares.
module tb_game_sequencer;

    logic       clck = 1'b0;
    logic       reset;
    logic [9:0] vgax;
    logic [8:0] vgay;
    logic       start_btn;
    logic       paddle_hit;
    logic [9:0] ball_y;

    logic       ball_rst, update, game_over;
    logic [2:0] lives;
    logic [7:0] score;
    logic       ball_rst2, update2, game_over2;
    logic [2:0] lives2;
    logic [1:0] score2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit m_play   = 0;

    typedef struct {
        int         at;
        string      name;
        logic       br;
        logic [2:0] lv;
        logic [7:0] sc;
        logic [1:0] sc2;
        logic       go;
    } snap_t;

    snap_t snap_q[$];
    int    upd_q[$];

    game_sequencer #(.SCORE_W(8)) dut (
        .clck(clck), .reset(reset), .vgax(vgax), .vgay(vgay),
        .start_btn(start_btn), .paddle_hit(paddle_hit), .ball_y(ball_y),
        .ball_rst(ball_rst), .update(update), .lives(lives),
        .score(score), .game_over(game_over)
    );

    game_sequencer #(.SCORE_W(2)) dut2 (
        .clck(clck), .reset(reset), .vgax(vgax), .vgay(vgay),
        .start_btn(start_btn), .paddle_hit(paddle_hit), .ball_y(ball_y),
        .ball_rst(ball_rst2), .update(update2), .lives(lives2),
        .score(score2), .game_over(game_over2)
    );

    always #5 clck = ~clck;

    always @(posedge clck) cyc <= cyc + 1;

    // Monitor: update pulses against expected cycles, and snapshots due this cycle.
    always @(negedge clck) begin
        bit exp_u;
        exp_u = (upd_q.size() > 0) && (upd_q[0] == cyc);
        if (exp_u || update === 1'b1 || update2 === 1'b1) begin
            checks++;
            if (update !== exp_u || update2 !== exp_u) begin
                failures++;
                $display("FAIL update cyc=%0d got=%b/%b want=%b", cyc, update, update2, exp_u);
            end
            if (exp_u) void'(upd_q.pop_front());
        end
        while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            checks++;
            if (s.at != cyc || ball_rst !== s.br || lives !== s.lv || score !== s.sc ||
                game_over !== s.go || ball_rst2 !== s.br || lives2 !== s.lv ||
                score2 !== s.sc2 || game_over2 !== s.go) begin
                failures++;
                $display("FAIL %s cyc=%0d got br=%b lives=%0d score=%0d score2=%0d go=%b | want br=%b lives=%0d score=%0d score2=%0d go=%b",
                         s.name, cyc, ball_rst, lives, score, score2, game_over,
                         s.br, s.lv, s.sc, s.sc2, s.go);
            end
        end
    end

    task automatic expect_now(input string name, input logic br, input logic [2:0] lv,
                              input logic [7:0] sc, input logic go);
        snap_t s;
        s.at   = cyc;
        s.name = name;
        s.br   = br;
        s.lv   = lv;
        s.sc   = sc;
        s.sc2  = (sc > 8'd3) ? 2'd3 : sc[1:0];
        s.go   = go;
        snap_q.push_back(s);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clck);
            #1;
        end
    endtask

    // One frame: one cycle at the origin, then three cycles elsewhere.
    task automatic frame(input bit hit);
        vgax = 10'd0;
        vgay = 9'd0;
        paddle_hit = hit;
        if (m_play) upd_q.push_back(cyc + 1);
        step(1);
        vgax = 10'd5;
        vgay = 9'd5;
        paddle_hit = 1'b0;
        step(3);
    endtask

    task automatic hit();
        paddle_hit = 1'b1;
        step(1);
        paddle_hit = 1'b0;
        step(1);
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        step(1);
    endtask

    task automatic serve(input logic [2:0] lv, input logic [7:0] sc);
        repeat (59) frame(0);
        expect_now("serve59", 1'b1, lv, sc, 1'b0);
        frame(0);
        m_play = 1;
        expect_now("serve_to_play", 1'b0, lv, sc, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start_btn = 1'b1;
        vgax = 10'd5;
        vgay = 9'd5;
        paddle_hit = 1'b0;
        ball_y = 10'd100;
        step(3);
        expect_now("reset_state", 1'b1, 3'd3, 8'd0, 1'b0);

        // Button held through reset must not start a game.
        reset = 1'b0;
        step(3);
        start_btn = 1'b0;
        step(2);
        repeat (62) frame(0);
        expect_now("idle_no_start", 1'b1, 3'd3, 8'd0, 1'b0);

        press_start();
        expect_now("start_press", 1'b1, 3'd3, 8'd0, 1'b0);
        hit();
        hit();
        expect_now("serve_hits_ignored", 1'b1, 3'd3, 8'd0, 1'b0);
        serve(3'd3, 8'd0);

        frame(0);
        frame(0);
        hit();
        frame(1);
        hit();
        expect_now("score3", 1'b0, 3'd3, 8'd3, 1'b0);

        ball_y = 10'd475;
        frame(0);
        ball_y = 10'd100;
        m_play = 0;
        expect_now("miss1", 1'b1, 3'd2, 8'd3, 1'b0);

        serve(3'd2, 8'd3);
        ball_y = 10'd470;
        frame(1);
        ball_y = 10'd100;
        m_play = 0;
        expect_now("miss_and_hit", 1'b1, 3'd1, 8'd4, 1'b0);

        serve(3'd1, 8'd4);
        ball_y = 10'd469;
        frame(0);
        expect_now("below_miss_y", 1'b0, 3'd1, 8'd4, 1'b0);
        ball_y = 10'd1023;
        frame(0);
        ball_y = 10'd100;
        m_play = 0;
        expect_now("game_over", 1'b1, 3'd0, 8'd4, 1'b1);
        frame(0);
        frame(0);
        hit();
        expect_now("over_frozen", 1'b1, 3'd0, 8'd4, 1'b1);

        press_start();
        expect_now("restart", 1'b1, 3'd3, 8'd0, 1'b0);
        serve(3'd3, 8'd0);
        repeat (5) hit();
        expect_now("score_sat", 1'b0, 3'd3, 8'd5, 1'b0);

        // Reset coincident with a frame tick in PLAY: no update may follow.
        vgax = 10'd0;
        vgay = 9'd0;
        reset = 1'b1;
        m_play = 0;
        step(1);
        expect_now("mid_reset", 1'b1, 3'd3, 8'd0, 1'b0);
        vgax = 10'd5;
        vgay = 9'd5;
        step(2);
        reset = 1'b0;
        step(1);
        frame(0);
        frame(0);
        expect_now("post_reset_idle", 1'b1, 3'd3, 8'd0, 1'b0);

        step(3);
        checks++;
        if (upd_q.size() != 0 || snap_q.size() != 0) begin
            failures++;
            $display("FAIL pending got upd=%0d snap=%0d want 0/0", upd_q.size(), snap_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
